// File: rtl/pipe_alu_pkg.sv
// +------------------------------------------------------------------+
// | pipe_alu_pkg : opcodes and width helpers shared by pipe_alu_mac   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pipe_alu_pkg;

  localparam int OP_BITS = 3;

  typedef enum logic [OP_BITS-1:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_MUL    = 3'b101,
    OP_MAC    = 3'b110,
    OP_CLRACC = 3'b111
  } op_e;

  // Leaves four bits of headroom above the full product for accumulation.
  function automatic int acc_bits_default(input int nbits);
    return 2 * nbits + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage.sv
// +------------------------------------------------------------------+
// | pipe_stage : one valid/data register slice with enable and reset  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Data only loads with a valid beat so bubbles leave the last result visible.
  always_ff @(posedge clk) begin
    if (res) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_alu_mac.sv
// +------------------------------------------------------------------+
// | pipe_alu_mac : pipelined ALU with saturating multiply-accumulate  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_alu_mac
  import pipe_alu_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int STAGES   = 2,
  parameter int ACC_BITS = acc_bits_default(NBITS)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NBITS-1:0]    a,
  input  logic [NBITS-1:0]    b,
  input  logic [OP_BITS-1:0]  opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] y,
  output logic                co
);

  localparam int PW = 2 * NBITS;
  localparam int SW = ((ACC_BITS > PW) ? ACC_BITS : PW) + 1;
  localparam int DW = ACC_BITS + 1;
  localparam logic [ACC_BITS-1:0] ACC_MAX = '1;

  logic                accept;
  logic [ACC_BITS-1:0] acc_q;
  logic [ACC_BITS-1:0] acc_d;
  logic [ACC_BITS-1:0] res_y;
  logic                res_co;
  logic [NBITS:0]      add_s;
  logic [NBITS-1:0]    sub_s;
  logic [PW-1:0]       prod;
  logic [SW-1:0]       mac_s;
  logic                mac_sat;

  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  assign add_s   = {1'b0, a} + {1'b0, b};
  assign sub_s   = a - b;
  assign prod    = PW'(a) * PW'(b);
  assign mac_s   = SW'(acc_q) + SW'(prod);
  assign mac_sat = (mac_s > SW'(ACC_MAX));

  always_comb begin
    res_y  = '0;
    res_co = 1'b0;
    acc_d  = acc_q;
    case (op_e'(opcode))
      OP_ADD: begin
        res_y  = ACC_BITS'(add_s);
        res_co = add_s[NBITS];
      end
      OP_SUB: begin
        res_y  = ACC_BITS'(sub_s);
        res_co = (b > a);
      end
      OP_AND: res_y = ACC_BITS'(a & b);
      OP_OR:  res_y = ACC_BITS'(a | b);
      OP_XOR: res_y = ACC_BITS'(a ^ b);
      OP_MUL: res_y = ACC_BITS'(prod);
      OP_MAC: begin
        acc_d  = mac_sat ? ACC_MAX : ACC_BITS'(mac_s);
        res_y  = acc_d;
        res_co = mac_sat;
      end
      OP_CLRACC: acc_d = '0;
      default: ;
    endcase
  end

  // Accumulator advances at accept time so chained MACs see each other immediately.
  always_ff @(posedge clk) begin
    if (res) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= acc_d;
    end
  end

  logic [STAGES:0]         stg_vld;
  logic [STAGES:0][DW-1:0] stg_dat;

  assign stg_vld[0] = in_valid;
  assign stg_dat[0] = {res_co, res_y};

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage #(
      .WIDTH (DW)
    ) u_stage (
      .clk     (clk),
      .res     (res),
      .en_i    (in_ready),
      .valid_i (stg_vld[g]),
      .data_i  (stg_dat[g]),
      .valid_o (stg_vld[g+1]),
      .data_o  (stg_dat[g+1])
    );
  end

  assign out_valid = stg_vld[STAGES];
  assign {co, y}   = stg_dat[STAGES];

endmodule

`default_nettype wire

// File: doc/pipe_alu_mac.md
PIPE_ALU_MAC -- requirements
Module: pipe_alu_mac

Interface
REQ-001 SHALL have parameter NBITS, default 8, operand width (2..16).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth from accept to output (1..4).
REQ-003 SHALL have parameter ACC_BITS, default 2*NBITS+4, accumulator and result width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port res  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  operand beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port a  input  NBITS  operand A, unsigned.
REQ-009 SHALL have port b  input  NBITS  operand B, unsigned.
REQ-010 SHALL have port opcode  input  3  operation select.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port y  output  ACC_BITS  result, zero-extended.
REQ-014 SHALL have port co  output  1  carry/borrow/saturation flag.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready; out_valid && out_ready completes a result.
REQ-016 SHALL decode opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 MAC, 111 CLRACC.
REQ-017 SHALL compute ADD as y = a+b over NBITS+1 bits, co = bit NBITS of the sum.
REQ-018 SHALL compute SUB as y = (a-b) mod 2^NBITS, co = 1 when b > a (borrow).
REQ-019 SHALL compute AND/OR/XOR bitwise on NBITS, co = 0.
REQ-020 SHALL compute MUL as the full 2*NBITS unsigned product, co = 0; accumulator untouched.
REQ-021 SHALL compute MAC as acc <= sat(acc + a*b) at accept; y = updated acc; co = 1 if saturation occurred on this beat.
REQ-022 SHALL saturate MAC at 2^ACC_BITS-1; accumulator never wraps.
REQ-023 SHALL execute CLRACC as acc <= 0, y = 0, co = 0.
REQ-024 SHALL update the accumulator only on accepted beats, in accept order, so back-to-back MACs chain with no bubble.
REQ-025 SHALL present each result exactly STAGES cycles after accept when never stalled; results leave in accept order.
REQ-026 SHALL stall the whole pipeline when out_valid && !out_ready: all stages hold, y/co/out_valid stay stable.
REQ-027 SHALL drive in_ready = !(out_valid && !out_ready) combinationally; no beat is accepted or lost during a stall.
REQ-028 SHALL insert a bubble (valid = 0) into stage 1 on any cycle with in_ready = 1 and in_valid = 0.
REQ-029 SHALL ignore a, b, opcode when no beat is accepted.

Reset
REQ-030 SHALL, on res = 1 at a clock edge, clear all stage valid bits, accumulator, y and co to 0.
REQ-031 SHALL discard in-flight beats when res is asserted mid-operation; no result for them is ever output.
REQ-032 SHALL give res priority over any simultaneous accept or output handshake; in_ready is 1 in the first cycle after reset.

Structure
REQ-033 SHALL keep opcode constants and the ACC_BITS default formula in shared package pipe_alu_pkg.
REQ-034 SHALL build each register stage from one sub-module pipe_stage (parameterised data width, enable, valid, sync reset), instantiated STAGES times by generate.

Verification (NBITS=8, STAGES=2, ACC_BITS=20)
REQ-035 SHALL cover ADD 200,100 -> y=300, co=1, out_valid exactly 2 cycles after accept.
REQ-036 SHALL cover SUB 5,10 -> y=251, co=1; MUL 255,255 -> y=65025, co=0.
REQ-037 SHALL cover CLRACC; MAC 10,20; MAC 3,4 back-to-back -> y=0, 200, 212 on consecutive cycles.
REQ-038 SHALL cover CLRACC then 17 MAC 255,255 -> 16th y=1040400 co=0; 17th y=1048575 co=1; further MAC holds 1048575, co=1.
REQ-039 SHALL cover out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, y stable, all beats later delivered in order, none lost.
REQ-040 SHALL cover res pulse with 2 beats in flight -> out_valid=0 next cycle, y=0, acc=0, subsequent MAC 2,3 -> y=6.
